// File: rtl/hash_pipe_nonce_sched.sv
// hash_pipe_nonce_sched
// Job controller for a fully pipelined SHA-256 quad pipeline. It accepts a
// message template, a start nonce and a nonce count. It issues one
// nonce-substituted message per cycle and follows results across the fixed
// pipeline latency. Each digest is screened for a leading-zero target, and
// qualifying nonces are queued in a small hit FIFO for the host.
// Optional feature: define HASHPIPE_ABORT_EN so that cmd_abort ends issue early.
module hash_pipe_nonce_sched #(
    parameter int PIPE_LAT   = 16,
    parameter int NONCE_WORD = 3,
    parameter int HIT_DEPTH  = 4,
    parameter int WORDBITS   = 32,
    parameter int MSGBITS    = 512,
    parameter int HASHBITS   = 256
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                job_valid,
    output logic                job_ready,
    input  logic [MSGBITS-1:0]  job_msg,
    input  logic [WORDBITS-1:0] job_nonce,
    input  logic [WORDBITS-1:0] job_count,
    input  logic [5:0]          cfg_zbits,
    input  logic                cmd_abort,
    output logic [MSGBITS-1:0]  msg_out,
    output logic                msg_valid,
    input  logic [HASHBITS-1:0] hash_in,
    output logic                hit_valid,
    input  logic                hit_ready,
    output logic [WORDBITS-1:0] hit_nonce,
    output logic                hit_ovf,
    output logic                busy,
    output logic                done
);

    localparam int PTR_W = $clog2(HIT_DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam int REM_W = WORDBITS + 1;

    localparam logic [WORDBITS-1:0] NONCE_ONE = 1;
    localparam logic [REM_W-1:0]    REM_ONE   = 1;
    localparam logic [REM_W-1:0]    REM_FULL  = REM_ONE << WORDBITS;
    localparam logic [PTR_W-1:0]    PTR_ONE   = 1;
    localparam logic [CNT_W-1:0]    CNT_DEPTH = CNT_W'(HIT_DEPTH);

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_DRAIN,
        S_DONE
    } state_t;

    // Job FSM and issue registers
    state_t              r_state;
    logic                r_job_ready;
    logic                r_busy;
    logic                r_done;
    logic                r_msg_valid;
    logic [MSGBITS-1:0]  r_msg_out;
    logic [MSGBITS-1:0]  r_tmpl;
    logic [WORDBITS-1:0] r_nonce;
    logic [REM_W-1:0]    r_remain;
    logic [5:0]          r_zbits;

    // Result tracking
    logic [PIPE_LAT-1:0] r_vld_dly;
    logic [WORDBITS-1:0] r_ret_nonce;

    // Hit FIFO
    logic [WORDBITS-1:0] r_mem [HIT_DEPTH];
    logic [PTR_W-1:0]    r_wr_ptr;
    logic [PTR_W-1:0]    r_rd_ptr;
    logic [CNT_W-1:0]    r_count;
    logic                r_hit_ovf;

    logic                  w_abort;
    logic                  w_accept;
    logic [MSGBITS-1:0]    w_issue_msg;
    logic                  w_res_valid;
    logic [2*WORDBITS-1:0] w_top;
    logic [2*WORDBITS-1:0] w_mask;
    logic                  w_hit;
    logic                  w_push;
    logic                  w_pop;
    logic                  w_full;
    logic                  w_not_empty;
    logic                  w_wr_en;
    logic                  w_unused;

`ifdef HASHPIPE_ABORT_EN
    assign w_abort  = cmd_abort;
    assign w_unused = ^hash_in[HASHBITS-1:2*WORDBITS];
`else
    // The abort port is present for pin compatibility but has no effect.
    assign w_abort  = 1'b0;
    assign w_unused = ^{cmd_abort, hash_in[HASHBITS-1:2*WORDBITS]};
`endif

    assign w_accept = (r_state == S_IDLE) && job_valid && r_job_ready;

    // Build the next message: the latched template with the nonce word replaced
    always_comb begin
        // NOTE: assign every always_comb output a default first so no path leaves it unassigned, which would infer a latch.
        w_issue_msg = r_tmpl;
        w_issue_msg[NONCE_WORD*WORDBITS +: WORDBITS] = r_nonce;
    end

    // Job FSM: accept, issue one message per RUN cycle, wait for returns, pulse done
    always_ff @(posedge clk) begin
        // NOTE: state is updated with non-blocking assignments only, so every register samples pre-edge values.
        if (!rst_n) begin
            r_state     <= S_IDLE;
            r_job_ready <= 1'b0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
            r_msg_valid <= 1'b0;
            r_msg_out   <= '0;
            r_tmpl      <= '0;
            r_nonce     <= '0;
            r_remain    <= '0;
            r_zbits     <= '0;
        end else begin
            r_done      <= 1'b0;
            r_msg_valid <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    r_job_ready <= 1'b1;
                    if (w_accept) begin
                        r_tmpl      <= job_msg;
                        r_nonce     <= job_nonce;
                        r_remain    <= (job_count == '0) ? REM_FULL : {1'b0, job_count};
                        r_zbits     <= cfg_zbits;
                        r_job_ready <= 1'b0;
                        r_busy      <= 1'b1;
                        r_state     <= S_RUN;
                    end
                end
                S_RUN: begin
                    if (w_abort) begin
                        r_remain <= '0;
                        r_state  <= S_DRAIN;
                    end else begin
                        r_msg_out   <= w_issue_msg;
                        r_msg_valid <= 1'b1;
                        r_nonce     <= r_nonce + NONCE_ONE;
                        r_remain    <= r_remain - REM_ONE;
                        if (r_remain == REM_ONE) begin
                            r_state <= S_DRAIN;
                        end
                    end
                end
                S_DRAIN: begin
                    // The issue register counts as the head of the delay line.
                    if (!r_msg_valid && (r_vld_dly == '0)) begin
                        r_done  <= 1'b1;
                        r_state <= S_DONE;
                    end
                end
                S_DONE: begin
                    r_busy      <= 1'b0;
                    r_job_ready <= 1'b1;
                    r_state     <= S_IDLE;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    // Valid delay line matching the pipeline depth; its last stage tags hash_in
    generate
        if (PIPE_LAT == 1) begin : g_dly_one
            always_ff @(posedge clk) begin
                if (!rst_n) r_vld_dly <= '0;
                else        r_vld_dly <= r_msg_valid;
            end
        end else begin : g_dly_many
            always_ff @(posedge clk) begin
                if (!rst_n) r_vld_dly <= '0;
                else        r_vld_dly <= {r_vld_dly[PIPE_LAT-2:0], r_msg_valid};
            end
        end
    endgenerate

    assign w_res_valid = r_vld_dly[PIPE_LAT-1];

    // Return-nonce counter: issue is contiguous, so results arrive in nonce order
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_ret_nonce <= '0;
        end else if (w_accept) begin
            r_ret_nonce <= job_nonce;
        end else if (w_res_valid) begin
            r_ret_nonce <= r_ret_nonce + NONCE_ONE;
        end
    end

    // Leading-zero screen over D = H[0] || H[1] ..., MSB first; only the first 64 bits matter
    always_comb begin
        w_top  = {hash_in[0 +: WORDBITS], hash_in[WORDBITS +: WORDBITS]};
        w_mask = ~({(2*WORDBITS){1'b1}} >> r_zbits);
        w_hit  = (w_top & w_mask) == '0;
    end

    assign w_not_empty = (r_count != '0);
    assign w_full      = (r_count == CNT_DEPTH);
    assign w_push      = w_res_valid && w_hit;
    assign w_pop       = w_not_empty && hit_ready;
    // A full FIFO still takes a push when the head leaves in the same cycle.
    assign w_wr_en     = w_push && (!w_full || w_pop);

    // Hit FIFO storage
    always_ff @(posedge clk) begin
        // NOTE: storage is deliberately not reset; the count governs validity and hit_nonce is masked while empty.
        if (w_wr_en) begin
            r_mem[r_wr_ptr] <= r_ret_nonce;
        end
    end

    // Hit FIFO pointers, occupancy and sticky overflow flag
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_wr_ptr  <= '0;
            r_rd_ptr  <= '0;
            r_count   <= '0;
            r_hit_ovf <= 1'b0;
        end else begin
            if (w_wr_en) r_wr_ptr <= r_wr_ptr + PTR_ONE;
            if (w_pop)   r_rd_ptr <= r_rd_ptr + PTR_ONE;
            r_count <= r_count + CNT_W'(w_wr_en) - CNT_W'(w_pop);
            if (w_accept) begin
                r_hit_ovf <= 1'b0;
            end else if (w_push && !w_wr_en) begin
                r_hit_ovf <= 1'b1;
            end
        end
    end

    assign job_ready = r_job_ready;
    assign busy      = r_busy;
    assign done      = r_done;
    assign msg_valid = r_msg_valid;
    assign msg_out   = r_msg_out;
    assign hit_valid = w_not_empty;
    assign hit_nonce = w_not_empty ? r_mem[r_rd_ptr] : '0;
    assign hit_ovf   = r_hit_ovf;

endmodule

// File: tb/tb_hash_pipe_nonce_sched.sv
// tb_hash_pipe_nonce_sched
// Directed bench for hash_pipe_nonce_sched. It uses a stub pipeline that
// delays msg_out by PIPE_LAT cycles. In the stub, H[0] is the issued nonce
// word and every other digest word is 0xFFFFFFFF. Expected issues and hits
// are queued when a job is driven and popped as the DUT produces them.
// Define HASHPIPE_ABORT_EN for both RTL and bench to cover the abort path.
module tb_hash_pipe_nonce_sched;

    localparam int PIPE_LAT   = 16;
    localparam int NONCE_WORD = 3;
    localparam int HIT_DEPTH  = 4;
    localparam int WB         = 32;
    localparam int MB         = 512;
    localparam int HB         = 256;

    logic          clk       = 1'b0;
    logic          rst_n     = 1'b0;
    logic          job_valid = 1'b0;
    logic          job_ready;
    logic [MB-1:0] job_msg   = '0;
    logic [WB-1:0] job_nonce = '0;
    logic [WB-1:0] job_count = '0;
    logic [5:0]    cfg_zbits = '0;
    logic          cmd_abort = 1'b0;
    logic [MB-1:0] msg_out;
    logic          msg_valid;
    logic [HB-1:0] hash_in;
    logic          hit_valid;
    logic          hit_ready = 1'b0;
    logic [WB-1:0] hit_nonce;
    logic          hit_ovf;
    logic          busy;
    logic          done;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;
    int n_issued = 0;
    int acc      = 0;

    logic [MB-1:0] cur_tmpl = '0;
    logic [WB-1:0] exp_issue[$];
    logic [WB-1:0] exp_hit[$];
    logic [MB-1:0] stub [PIPE_LAT];

    hash_pipe_nonce_sched #(
        .PIPE_LAT  (PIPE_LAT),
        .NONCE_WORD(NONCE_WORD),
        .HIT_DEPTH (HIT_DEPTH),
        .WORDBITS  (WB),
        .MSGBITS   (MB),
        .HASHBITS  (HB)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .job_valid(job_valid),
        .job_ready(job_ready),
        .job_msg  (job_msg),
        .job_nonce(job_nonce),
        .job_count(job_count),
        .cfg_zbits(cfg_zbits),
        .cmd_abort(cmd_abort),
        .msg_out  (msg_out),
        .msg_valid(msg_valid),
        .hash_in  (hash_in),
        .hit_valid(hit_valid),
        .hit_ready(hit_ready),
        .hit_nonce(hit_nonce),
        .hit_ovf  (hit_ovf),
        .busy     (busy),
        .done     (done)
    );

    always #5 clk = ~clk;

    // Stub pipeline: PIPE_LAT-stage delay of msg_out
    always @(posedge clk) begin
        stub[0] <= msg_out;
        for (int i = 1; i < PIPE_LAT; i++) stub[i] <= stub[i-1];
    end

    always_comb begin
        hash_in = {8{32'hFFFF_FFFF}};
        hash_in[31:0] = stub[PIPE_LAT-1][NONCE_WORD*32 +: 32];
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [MB-1:0] obs, input logic [MB-1:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Independent hit model for the stub digest (H[1] is all ones).
    function automatic bit model_hit(input logic [WB-1:0] n, input int z);
        if (z == 0) return 1'b1;
        if (z <= 32) return (n >> (32 - z)) == '0;
        return 1'b0;
    endfunction

    // One clock: score a pop happening at this edge, then score the new issue.
    task automatic tick();
        logic [WB-1:0] en;
        logic [MB-1:0] em;
        if (hit_valid && hit_ready) begin
            check("hit_pending", exp_hit.size() != 0, 1);
            if (exp_hit.size() != 0) begin
                en = exp_hit.pop_front();
                check("hit_nonce", hit_nonce, en);
            end
        end
        @(posedge clk);
        cyc++;
        @(negedge clk);
        if (msg_valid) begin
            n_issued++;
            check("issue_pending", exp_issue.size() != 0, 1);
            if (exp_issue.size() != 0) begin
                en = exp_issue.pop_front();
                em = cur_tmpl;
                em[NONCE_WORD*32 +: 32] = en;
                check("msg_out", msg_out, em);
            end
        end
    endtask

    task automatic push_exp(input logic [WB-1:0] n0, input int n, input int z, input int max_hits);
        int h;
        logic [WB-1:0] v;
        h = 0;
        for (int i = 0; i < n; i++) begin
            v = n0 + WB'(i);
            exp_issue.push_back(v);
            if (model_hit(v, z) && h < max_hits) begin
                exp_hit.push_back(v);
                h++;
            end
        end
    endtask

    task automatic start_job(input logic [WB-1:0] seed, input logic [WB-1:0] n0,
                             input logic [WB-1:0] cnt, input logic [5:0] z);
        check("job_ready_idle", job_ready, 1);
        for (int i = 0; i < 16; i++) job_msg[i*32 +: 32] = seed ^ (32'h0101_0101 * WB'(i));
        cur_tmpl  = job_msg;
        job_nonce = n0;
        job_count = cnt;
        cfg_zbits = z;
        job_valid = 1'b1;
        tick();
        acc       = cyc;
        n_issued  = 0;
        job_valid = 1'b0;
        job_msg   = ~job_msg;
        job_nonce = 32'hDEAD_BEEF;
        cfg_zbits = ~z;
        check("busy_after_accept", busy, 1);
        check("ready_after_accept", job_ready, 0);
    endtask

    task automatic wait_done(input int exp_cyc, input int exp_n, input string tag);
        int k;
        k = 0;
        while (!done && k < 400) begin
            tick();
            k++;
        end
        check({tag, "_done_cycle"}, cyc, exp_cyc);
        check({tag, "_issue_count"}, n_issued, exp_n);
        tick();
        check({tag, "_done_one_cycle"}, done, 0);
        check({tag, "_ready_again"}, job_ready, 1);
        check({tag, "_not_busy"}, busy, 0);
    endtask

    task automatic drain_hits(input string tag);
        int k;
        k = 0;
        hit_ready = 1'b1;
        while (hit_valid && k < 50) begin
            tick();
            k++;
        end
        check({tag, "_fifo_empty"}, hit_valid, 0);
        check({tag, "_hits_left"}, exp_hit.size(), 0);
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_job_ready"}, job_ready, 0);
        check({tag, "_busy"}, busy, 0);
        check({tag, "_done"}, done, 0);
        check({tag, "_msg_valid"}, msg_valid, 0);
        check({tag, "_msg_out"}, msg_out, 0);
        check({tag, "_hit_valid"}, hit_valid, 0);
        check({tag, "_hit_nonce"}, hit_nonce, 0);
        check({tag, "_hit_ovf"}, hit_ovf, 0);
    endtask

    initial begin
        // Power-on reset
        repeat (3) tick();
        check_all_zero("reset");
        rst_n = 1'b1;
        tick();
        check("post_reset_ready", job_ready, 1);

        // Basic run: 8 nonces from 0x10, every result hits
        hit_ready = 1'b1;
        push_exp(32'h10, 8, 0, 99);
        start_job(32'hA5A5_0000, 32'h10, 8, 6'd0);
        wait_done(acc + 8 + PIPE_LAT + 2, 8, "basic");
        check("basic_ovf", hit_ovf, 0);
        drain_hits("basic");

        // Nonce wrap with a 31-bit zero target
        push_exp(32'hFFFF_FFFE, 4, 31, 99);
        start_job(32'h1234_5678, 32'hFFFF_FFFE, 4, 6'd31);
        wait_done(acc + 4 + PIPE_LAT + 2, 4, "wrap");
        drain_hits("wrap");

        // Target boundary at the H[0]/H[1] seam
        for (int z = 32; z <= 33; z++) begin
            push_exp(32'h0, 2, z, 99);
            start_job(32'h0BAD_F00D, 32'h0, 2, 6'(z));
            wait_done(acc + 2 + PIPE_LAT + 2, 2, "seam");
            drain_hits("seam");
        end

        // Overflow: six hits with no consumer, only the first four are kept
        hit_ready = 1'b0;
        push_exp(32'h100, 6, 0, HIT_DEPTH);
        start_job(32'h5555_AAAA, 32'h100, 6, 6'd0);
        wait_done(acc + 6 + PIPE_LAT + 2, 6, "ovf");
        check("ovf_flag", hit_ovf, 1);
        check("ovf_head_valid", hit_valid, 1);
        check("ovf_head_nonce", hit_nonce, 32'h100);
        drain_hits("ovf");
        check("ovf_sticky", hit_ovf, 1);

        // Full FIFO with a pop in the same cycle as a new hit
        hit_ready = 1'b0;
        push_exp(32'h200, 5, 0, 99);
        start_job(32'h7777_0001, 32'h200, 5, 6'd0);
        check("ovf_cleared_on_accept", hit_ovf, 0);
        while (cyc < acc + PIPE_LAT + 5) tick();
        check("full_head_valid", hit_valid, 1);
        hit_ready = 1'b1;
        wait_done(acc + 5 + PIPE_LAT + 2, 5, "fullpp");
        check("fullpp_no_ovf", hit_ovf, 0);
        drain_hits("fullpp");

        // Reset in the 5th issue cycle of a long job
        push_exp(32'h300, 100, 0, 99);
        start_job(32'h3333_CCCC, 32'h300, 100, 6'd0);
        repeat (5) tick();
        check("pre_reset_issues", n_issued, 5);
        exp_issue.delete();
        exp_hit.delete();
        rst_n = 1'b0;
        tick();
        check_all_zero("midreset");
        rst_n = 1'b1;
        for (int i = 0; i < PIPE_LAT + 4; i++) begin
            tick();
            check("midreset_no_hit", hit_valid, 0);
        end
        check("midreset_idle_ready", job_ready, 1);

`ifdef HASHPIPE_ABORT_EN
        // Abort in the 10th RUN cycle: nine issues, nine hits, then done
        push_exp(32'h400, 9, 0, 99);
        start_job(32'h4444_0000, 32'h400, 100, 6'd0);
        repeat (9) tick();
        cmd_abort = 1'b1;
        tick();
        cmd_abort = 1'b0;
        wait_done(acc + 9 + PIPE_LAT + 2, 9, "abort");
        drain_hits("abort");
`else
        // Abort input is inert: the job runs to its full count
        push_exp(32'h400, 12, 0, 99);
        start_job(32'h4444_0000, 32'h400, 12, 6'd0);
        repeat (2) tick();
        cmd_abort = 1'b1;
        tick();
        cmd_abort = 1'b0;
        wait_done(acc + 12 + PIPE_LAT + 2, 12, "noabort");
        drain_hits("noabort");
`endif

        check("issues_left", exp_issue.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/hash_pipe_nonce_sched.md
# hash_pipe_nonce_sched

Controller that drives a fully pipelined SHA-256 quad pipeline. It accepts a job: a 512-bit message template, a start nonce and a nonce count. It issues one message per cycle with the nonce word substituted, tracks in-flight results across the fixed pipeline latency, and screens each returned digest for a leading-zero target. Qualifying nonces are queued in a small hit FIFO for the host. It sits between the host/job interface and the message input and hash output of the hash pipeline.

## Interface
- `PIPE_LAT`, 16: cycles from `msg_out` presented to matching digest on `hash_in`; must be ≥1.
- `NONCE_WORD`, 3: message word index (0..15) replaced by the nonce.
- `HIT_DEPTH`, 4: hit FIFO entries; power of 2, ≥2.
- `WORDBITS`, 32; `MSGBITS`, 512; `HASHBITS`, 256.

Ports:
- `clk` in 1: single clock, rising edge.
- `rst_n` in 1: synchronous, active-low reset.
- `job_valid` in 1; `job_ready` out 1: job handshake.
- `job_msg` in MSGBITS: template; word i = bits [32i+31:32i].
- `job_nonce` in 32: first nonce.
- `job_count` in 32: nonces to issue; 0 means 2^32.
- `cfg_zbits` in 6: required leading zero bits of the digest (0..63). Sampled at job accept.
- `cmd_abort` in 1: stop issuing (see Configuration).
- `msg_out` out MSGBITS; `msg_valid` out 1: to pipeline input.
- `hash_in` in HASHBITS: finalized digest; H[i] = bits [32i+31:32i].
- `hit_valid` out 1; `hit_ready` in 1; `hit_nonce` out 32: hit FIFO head.
- `hit_ovf` out 1: sticky; a hit was dropped.
- `busy` out 1: state ≠ IDLE.
- `done` out 1: one-cycle pulse at job completion.

## Operation
- The FSM has four states: IDLE, RUN, DRAIN, DONE.
- **IDLE:**
  - `job_ready`=1.
  - On `job_valid`: latch template, nonce, 33-bit remaining count (0→2^32) and zbits. Clear `hit_ovf`. Go to RUN.
- **RUN:**
  - Each cycle: register `msg_out` = template with word NONCE_WORD = current nonce; `msg_valid`=1.
  - Nonce increments mod 2^32; 0xFFFFFFFF wraps to 0x00000000.
  - Remaining count decrements. When it reaches 0 after an issue, go to DRAIN.
- **DRAIN:**
  - `msg_valid`=0.
  - Wait until the valid delay line is all-zero, meaning all results have returned. Then go to DONE.
- **DONE:** `done`=1 for one cycle, then IDLE. `job_valid` is ignored here.
- **Result tracking:**
  - A PIPE_LAT-deep shift register carries `msg_valid`. Its output tags `hash_in` as valid.
  - A return-nonce counter, loaded with `job_nonce` at accept, increments on each valid result and gives the result's nonce. No per-entry nonce storage is needed because issue is contiguous.
- **Hit test:**
  - The digest bitstring is D = H[0]‖H[1]‖…‖H[7], with MSB first.
  - A hit is when the first zbits bits of D are zero. zbits=0 means every result hits. zbits=33..63 spans H[0] and the top bits of H[1].
- **Hit FIFO:**
  - Push on a valid hit. Pop on `hit_valid`&`hit_ready`.
  - Push and pop in the same cycle while full is accepted with no drop.
  - A push while full without a pop drops the hit and sets `hit_ovf`.
  - FIFO contents persist across jobs.

## Timing
- Reset: every output is 0, the FSM is in IDLE, the delay line and FIFO are cleared, and `hit_ovf`=0. In-flight results from before reset are never reported.
- `job_ready` is high in IDLE.
- The first `msg_valid` occurs the cycle after accept.
- For a job of N nonces, `msg_valid` is high for exactly N consecutive cycles.
- The result for a message presented at cycle t is sampled at t+PIPE_LAT.
- `hit_valid` rises the cycle after the hit result is sampled.
- `done` is asserted at accept+N+PIPE_LAT+2.
- `hit_valid` stays asserted with `hit_nonce` stable until popped.
- `cmd_abort` never affects DRAIN, DONE or IDLE.

## Configuration
- Macro: `HASHPIPE_ABORT_EN`.
- **Defined:**
  - `cmd_abort`=1 in RUN stops issue from that cycle: no `msg_valid` that cycle.
  - The FSM goes to DRAIN. Already-issued results are still checked and `done` still pulses.
  - Remaining count is discarded.
- **Undefined:** the `cmd_abort` port exists but is ignored; jobs always run to count.

## Test plan
The bench uses a stub pipeline: a PIPE_LAT-stage delay of `msg_out`, with H[0] = issued word NONCE_WORD and other words 0xFFFFFFFF.
- **Basic run:**
  - Stimulus: job with nonce=0x10, count=8, zbits=0.
  - Response: 8 `msg_valid` cycles with words 0x10..0x17; 8 hits 0x10..0x17 in order with `hit_ready`=1; `done` at accept+26; `hit_ovf`=0.
- **Wrap and zero filter:**
  - Stimulus: nonce=0xFFFFFFFE, count=4, zbits=31.
  - Response: issued 0xFFFFFFFE, 0xFFFFFFFF, 0x0, 0x1. Hits are only 0x00000000 and 0x00000001.
- **Overflow:**
  - Stimulus: count=6, zbits=0, `hit_ready`=0.
  - Response: FIFO holds the first 4 nonces and `hit_ovf`=1. Popping yields those 4, then `hit_valid`=0.
- **Full push+pop:**
  - Stimulus: FIFO full, with `hit_ready`=1 in the same cycle as a new hit.
  - Response: no drop; `hit_ovf` stays 0.
- **Reset mid-run:**
  - Stimulus: `rst_n`=0 at the 5th issue cycle of count=100.
  - Response: next cycle all outputs are 0 and state is IDLE. No hits appear during the following PIPE_LAT cycles.
- **Abort (`HASHPIPE_ABORT_EN` defined):**
  - Stimulus: count=100, `cmd_abort` in the 10th RUN cycle.
  - Response: exactly 9 issues, 9 hits with zbits=0, then `done`.
